// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse-stream blocks.
//   pulse_batcher_state_t : batcher FSM states
//   sat_max(width)        : largest value representable in 'width' bits
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OFFER = 2'd2
  } pulse_batcher_state_t;

  // All-ones value for an unsigned field of the given width.
  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at its maximum value.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   increment    : add one unless already saturated
//   clear        : return to zero (wins over increment)
//   count        : current value
//   saturated    : registered flag, high exactly while count == max
module saturating_counter
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             saturated
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(sat_max(WIDTH));

  logic [WIDTH-1:0] count_d;

  // Next count: clear first, then a non-saturating increment.
  always_comb begin
    count_d = count;
    if (clear) begin
      count_d = '0;
    end else if (increment && !saturated) begin
      count_d = count + WIDTH'(1);
    end
  end

  // Saturation flag tracks the next count so it is aligned with count.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      saturated <= 1'b0;
    end else begin
      count     <= count_d;
      saturated <= (count_d == MAX_COUNT);
    end
  end

endmodule

// File: rtl/pulse_batcher.sv
// Groups incoming pulses into counted batches for a valid/ready consumer.
// A batch launches when the pulse count reaches BATCH_THRESHOLD or when a
// partial batch sees TIMEOUT_CYCLES pulse-free cycles. Pulses keep
// accumulating while a batch is stalled; beyond saturation they are dropped
// and flagged on the sticky overflow output.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   pulse_in       : one pulse per sampled high cycle
//   batch_valid    : batch offered
//   batch_ready    : consumer accepts when high with batch_valid
//   batch_count    : pulse count of the offered batch
//   busy           : accumulator saturated
//   overflow       : sticky, at least one pulse dropped
//   clear_overflow : clears overflow (a coincident drop wins)
module pulse_batcher
  import pulse_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH     = 4,
  parameter int unsigned BATCH_THRESHOLD = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pulse_in,
  output logic                   batch_valid,
  input  logic                   batch_ready,
  output logic [COUNT_WIDTH-1:0] batch_count,
  output logic                   busy,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [COUNT_WIDTH-1:0] THRESHOLD = COUNT_WIDTH'(BATCH_THRESHOLD);
  localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  // Parameter legality checks at elaboration.
  if (BATCH_THRESHOLD < 1 || BATCH_THRESHOLD > sat_max(COUNT_WIDTH)) begin : g_bad_threshold
    $error("pulse_batcher: BATCH_THRESHOLD out of range 1..2^COUNT_WIDTH-1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("pulse_batcher: TIMEOUT_CYCLES must be >= 1");
  end

  pulse_batcher_state_t state_q, state_d;

  logic [COUNT_WIDTH-1:0] acc;
  logic                   acc_sat;
  logic                   acc_inc;
  logic                   acc_clr;
  logic [COUNT_WIDTH-1:0] sum;
  logic                   at_threshold;
  logic                   drop;

  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   batch_valid_d;
  logic [COUNT_WIDTH-1:0] batch_count_d;
  logic                   overflow_d;
  logic                   launch;

  saturating_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_acc (
    .clock     (clock),
    .reset     (reset),
    .increment (acc_inc),
    .clear     (acc_clr),
    .count     (acc),
    .saturated (acc_sat)
  );

  // Saturating acc + pulse_in; a pulse arriving at saturation is dropped.
  assign sum          = acc_sat ? acc : acc + COUNT_WIDTH'(pulse_in);
  assign at_threshold = (sum >= THRESHOLD);
  assign drop         = pulse_in && acc_sat;
  assign busy         = acc_sat;

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      batch_valid <= 1'b0;
      batch_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      batch_valid <= batch_valid_d;
      batch_count <= batch_count_d;
      overflow    <= overflow_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    batch_valid_d = batch_valid;
    batch_count_d = batch_count;
    acc_inc       = pulse_in;
    acc_clr       = 1'b0;
    launch        = 1'b0;

    // Set wins over clear.
    overflow_d = overflow;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          if (at_threshold) begin
            launch = 1'b1;
          end else begin
            state_d = ACCUM;
            timer_d = '0;
          end
        end
      end

      ACCUM: begin
        if (at_threshold) begin
          launch = 1'b1;
        end else if (pulse_in) begin
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          launch = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      OFFER: begin
        timer_d = '0;
        if (batch_ready) begin
          if (at_threshold) begin
            launch = 1'b1;
          end else if (sum != '0) begin
            state_d       = ACCUM;
            batch_valid_d = 1'b0;
          end else begin
            state_d       = IDLE;
            batch_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d       = IDLE;
        batch_valid_d = 1'b0;
        acc_clr       = 1'b1;
      end
    endcase

    // Launch hands the whole sum to the batch and restarts accumulation.
    if (launch) begin
      state_d       = OFFER;
      batch_valid_d = 1'b1;
      batch_count_d = sum;
      acc_clr       = 1'b1;
      timer_d       = '0;
    end
  end

endmodule

// File: tb/tb_pulse_batcher.sv
// Bench for pulse_batcher: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_pulse_batcher;

  localparam int CW   = 4;
  localparam int THR  = 4;
  localparam int TO   = 8;
  localparam int MAXV = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pulse_in = 1'b0;
  logic          batch_ready = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          batch_valid;
  logic [CW-1:0] batch_count;
  logic          busy;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Model state: pending batch, pulses held back, quiet-cycle count.
  int m_valid = 0;
  int m_count = 0;
  int m_acc   = 0;
  int m_quiet = 0;
  int m_ovf   = 0;
  int m_xfer  = 0;

  int dut_xfer    = 0;
  int dut_valid_q = 0;
  int dut_count_q = 0;

  pulse_batcher #(
    .COUNT_WIDTH     (CW),
    .BATCH_THRESHOLD (THR),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pulse_in       (pulse_in),
    .batch_valid    (batch_valid),
    .batch_ready    (batch_ready),
    .batch_count    (batch_count),
    .busy           (busy),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", name, cycle, got, exp);
    end
  endtask

  // Behavioural model advanced on each edge, then compared 1 time unit later.
  always begin
    int p, r, s;
    int was_valid;
    @(posedge clock);
    p = int'(pulse_in);
    r = int'(batch_ready);
    if (!reset && dut_valid_q != 0 && r != 0) dut_xfer += dut_count_q;
    if (reset) begin
      m_valid = 0; m_count = 0; m_acc = 0; m_quiet = 0; m_ovf = 0;
    end else begin
      s = (m_acc + p > MAXV) ? MAXV : m_acc + p;
      if (p != 0 && m_acc == MAXV) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
      if (m_valid != 0 && r == 0) begin
        m_acc = s;
      end else begin
        was_valid = m_valid;
        if (m_valid != 0) m_xfer += m_count;
        if (s >= THR) begin
          m_valid = 1; m_count = s; m_acc = 0; m_quiet = 0;
        end else if (p != 0 || was_valid != 0) begin
          m_valid = 0; m_acc = s; m_quiet = 0;
        end else if (s > 0) begin
          m_quiet++;
          if (m_quiet == TO) begin
            m_valid = 1; m_count = s; m_acc = 0; m_quiet = 0;
          end
        end
      end
    end
    #1;
    cycle++;
    chk("model_valid", int'(batch_valid), m_valid);
    if (m_valid != 0) chk("model_count", int'(batch_count), m_count);
    chk("model_busy", int'(busy), (m_acc == MAXV) ? 1 : 0);
    chk("model_overflow", int'(overflow), m_ovf);
    dut_valid_q = int'(batch_valid);
    dut_count_q = int'(batch_count);
  end

  task automatic step(input logic p, input logic r, input logic c, input logic rs);
    @(negedge clock);
    pulse_in       = p;
    batch_ready    = r;
    clear_overflow = c;
    reset          = rs;
    @(posedge clock);
    #2;
  endtask

  initial begin
    int base;
    int pd, rd;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", int'(batch_valid), 0);
    chk("rst_count", int'(batch_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);

    // 1: four separated pulses, ready high
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    chk("t1_not_early", int'(batch_valid), 0);
    step(1, 1, 0, 0);
    chk("t1_valid", int'(batch_valid), 1);
    chk("t1_count", int'(batch_count), 4);
    step(0, 1, 0, 0);
    chk("t1_one_cycle", int'(batch_valid), 0);

    // 2: partial batch of 2 launched by timeout
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      step(0, 1, 0, 0);
      chk("t2_not_early", int'(batch_valid), 0);
    end
    step(0, 1, 0, 0);
    chk("t2_valid", int'(batch_valid), 1);
    chk("t2_count", int'(batch_count), 2);
    step(0, 1, 0, 0);
    chk("t2_done", int'(batch_valid), 0);

    // 3: backpressure, accumulation behind a stalled batch
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    chk("t3_hold_valid", int'(batch_valid), 1);
    chk("t3_hold_count", int'(batch_count), 4);
    step(0, 1, 0, 0);
    chk("t3_b2b_valid", int'(batch_valid), 1);
    chk("t3_b2b_count", int'(batch_count), 6);
    step(0, 1, 0, 0);
    chk("t3_done", int'(batch_valid), 0);

    // 4: saturation and overflow
    for (int i = 0; i < 4 + 15; i++) step(1, 0, 0, 0);
    chk("t4_busy", int'(busy), 1);
    chk("t4_no_ovf_yet", int'(overflow), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    chk("t4_overflow", int'(overflow), 1);
    chk("t4_count4", int'(batch_count), 4);
    step(0, 1, 0, 0);
    chk("t4_count15", int'(batch_count), 15);
    chk("t4_busy_off", int'(busy), 0);
    step(0, 1, 0, 0);
    chk("t4_idle", int'(batch_valid), 0);
    chk("t4_ovf_sticky", int'(overflow), 1);
    step(0, 0, 1, 0);
    chk("t4_ovf_clr", int'(overflow), 0);
    chk("t4_busy_clr", int'(busy), 0);

    // 5: pulse level held for 10 cycles
    base = dut_xfer;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    for (int i = 0; i < TO + 2; i++) step(0, 1, 0, 0);
    chk("t5_total", dut_xfer - base, 10);
    chk("t5_no_ovf", int'(overflow), 0);

    // 6: reset while offering with acc=3
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    chk("t6_pre_valid", int'(batch_valid), 1);
    step(0, 0, 0, 1);
    chk("t6_valid", int'(batch_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_ovf", int'(overflow), 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    chk("t6_not_early", int'(batch_valid), 0);
    step(1, 1, 0, 0);
    chk("t6_fresh_count", int'(batch_count), 4);
    step(0, 1, 0, 0);

    // Randomized traffic with varying pulse and ready densities
    for (int seg = 0; seg < 10; seg++) begin
      pd = $urandom_range(5, 95);
      rd = $urandom_range(5, 95);
      for (int i = 0; i < 300; i++) begin
        step(logic'($urandom_range(0, 99) < pd),
             logic'($urandom_range(0, 99) < rd),
             logic'($urandom_range(0, 49) == 0),
             logic'($urandom_range(0, 999) == 0));
      end
    end
    for (int i = 0; i < 2 * TO; i++) step(0, 1, 0, 0);
    chk("xfer_total", dut_xfer, m_xfer);
    chk("drained", int'(batch_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
